// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter
// Merges the unstallable UART frame stream with the panel req/ack requester.
// Both sources feed one valid/ready command port toward the execution stage.
// UART frames are buffered in a small FIFO, and sources alternate on a tie.
module uart_cmd_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          uart_valid,
  input  logic [3:0]    uart_instr,
  input  logic [3:0]    uart_data,
  input  logic          pnl_req,
  input  logic [3:0]    pnl_instr,
  input  logic [3:0]    pnl_data,
  output logic          pnl_ack,
  output logic          cmd_valid,
  output logic [3:0]    cmd_instr,
  output logic [3:0]    cmd_data,
  output logic          cmd_src,
  input  logic          cmd_ready,
  output logic [CW-1:0] fifo_count,
  output logic          uart_overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [3:0]    FLUSH_INSTR = 4'hF;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t         state_reg;
  state_t         state_next;

  logic [7:0]     fifo_mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic [CW-1:0]  count_next;
  logic           overflow_reg;
  logic           flushed_reg;
  logic           last_src_reg;
  logic [3:0]     cmd_instr_reg;
  logic [3:0]     cmd_data_reg;
  logic           cmd_src_reg;
  logic           pnl_ack_reg;

  logic           flush;
  logic           push_req;
  logic           fifo_full;
  logic           uart_pend;
  logic           pnl_pend;
  logic           grant_uart;
  logic           grant_pnl;
  logic           complete;
  logic           pop;
  logic           push;
  logic [7:0]     head_entry;

  // A flush frame is a control strobe, never data.
  assign flush     = uart_valid && (uart_instr == FLUSH_INSTR);
  assign push_req  = uart_valid && (uart_instr != FLUSH_INSTR);
  assign fifo_full = (count_reg == FULL_COUNT);
  // Entries being flushed this cycle must not be granted.
  assign uart_pend = (count_reg != '0) && !flush;
  // While pnl_ack is high the panel still holds pnl_req for the retiring request.
  assign pnl_pend  = pnl_req && !pnl_ack_reg;
  assign head_entry = fifo_mem[rd_ptr_reg];

  // State register; reset abandons any presented command at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: a grant enters ISSUE, a handshake returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_uart || grant_pnl) state_next = ISSUE;
      ISSUE:   if (complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Arbitration and handshake control decoded from the current state.
  always_comb begin
    grant_uart = 1'b0;
    grant_pnl  = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (uart_pend && pnl_pend) begin
          // Tie: the source that did not go last wins.
          grant_uart = last_src_reg;
          grant_pnl  = !last_src_reg;
        end else begin
          grant_uart = uart_pend;
          grant_pnl  = pnl_pend;
        end
      end
      ISSUE:   complete = cmd_ready;
      default: ;
    endcase
  end

  // A pop after a flush would remove an entry that no longer exists.
  assign pop  = complete && !cmd_src_reg && !flush && !flushed_reg;
  // A full FIFO still takes a frame when a slot frees at the same edge.
  assign push = push_req && (!fifo_full || pop);

  // Occupancy update; flush wins over everything.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // FIFO storage: plain array with no reset so it maps onto RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {uart_instr, uart_data};
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (flush) begin
        rd_ptr_reg <= wr_ptr_reg;
      end else if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (flush) begin
        overflow_reg <= 1'b0;
      end else if (push_req && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Remembers that the command in flight lost its FIFO entry to a flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flushed_reg <= 1'b0;
    end else if (complete) begin
      flushed_reg <= 1'b0;
    end else if (flush && (state_reg == ISSUE)) begin
      flushed_reg <= 1'b1;
    end
  end

  // Command registers load on grant and hold through ISSUE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_instr_reg <= 4'h0;
      cmd_data_reg  <= 4'h0;
      cmd_src_reg   <= 1'b0;
    end else if (grant_uart) begin
      cmd_instr_reg <= head_entry[7:4];
      cmd_data_reg  <= head_entry[3:0];
      cmd_src_reg   <= 1'b0;
    end else if (grant_pnl) begin
      cmd_instr_reg <= pnl_instr;
      cmd_data_reg  <= pnl_data;
      cmd_src_reg   <= 1'b1;
    end
  end

  // Round-robin history and the panel acknowledge pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_src_reg <= 1'b1;
      pnl_ack_reg  <= 1'b0;
    end else begin
      if (complete) begin
        last_src_reg <= cmd_src_reg;
      end
      pnl_ack_reg <= complete && cmd_src_reg;
    end
  end

  assign cmd_valid     = (state_reg == ISSUE);
  assign cmd_instr     = cmd_instr_reg;
  assign cmd_data      = cmd_data_reg;
  assign cmd_src       = cmd_src_reg;
  assign pnl_ack       = pnl_ack_reg;
  assign fifo_count    = count_reg;
  assign uart_overflow = overflow_reg;

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Testbench for uart_cmd_arbiter: directed scenarios plus a randomized run
// checked against a queue-based model of the arbiter's behaviour.
module tb_uart_cmd_arbiter;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          uart_valid = 1'b0;
  logic [3:0]    uart_instr = 4'h0;
  logic [3:0]    uart_data = 4'h0;
  logic          pnl_req = 1'b0;
  logic [3:0]    pnl_instr = 4'h0;
  logic [3:0]    pnl_data = 4'h0;
  logic          pnl_ack;
  logic          cmd_valid;
  logic [3:0]    cmd_instr;
  logic [3:0]    cmd_data;
  logic          cmd_src;
  logic          cmd_ready = 1'b0;
  logic [CW-1:0] fifo_count;
  logic          uart_overflow;

  int checks = 0;
  int errors = 0;

  uart_cmd_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .uart_valid(uart_valid), .uart_instr(uart_instr), .uart_data(uart_data),
    .pnl_req(pnl_req), .pnl_instr(pnl_instr), .pnl_data(pnl_data), .pnl_ack(pnl_ack),
    .cmd_valid(cmd_valid), .cmd_instr(cmd_instr), .cmd_data(cmd_data), .cmd_src(cmd_src),
    .cmd_ready(cmd_ready), .fifo_count(fifo_count), .uart_overflow(uart_overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    uart_valid = 1'b0; uart_instr = 4'h0; uart_data = 4'h0;
    pnl_req = 1'b0; pnl_instr = 4'h0; pnl_data = 4'h0; cmd_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push(input logic [3:0] i, input logic [3:0] d);
    uart_valid = 1'b1; uart_instr = i; uart_data = d;
    tick();
    uart_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    checks++;
    if ({cmd_valid, cmd_instr, cmd_data, cmd_src, pnl_ack, fifo_count, uart_overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b i=%h d=%h s=%b ack=%b cnt=%0d ovf=%b want all 0",
               cmd_valid, cmd_instr, cmd_data, cmd_src, pnl_ack, fifo_count, uart_overflow);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_release got v=%b cnt=%0d want 0/0", cmd_valid, fifo_count);
    end
  endtask

  task automatic test_single_uart();
    do_reset();
    cmd_ready = 1'b1;
    push(4'h3, 4'h7);
    checks++;
    if (fifo_count !== 3'd1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_push got cnt=%0d v=%b want 1/0", fifo_count, cmd_valid);
    end
    tick();
    checks++;
    if ({cmd_valid, cmd_instr, cmd_data, cmd_src} !== {1'b1, 4'h3, 4'h7, 1'b0} || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL single_present got v=%b i=%h d=%h s=%b cnt=%0d want 1/3/7/0/1",
               cmd_valid, cmd_instr, cmd_data, cmd_src, fifo_count);
    end
    $display("txn single src=%0d instr=%h data=%h", cmd_src, cmd_instr, cmd_data);
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL single_done got v=%b cnt=%0d want 0/0", cmd_valid, fifo_count);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] ei, ed;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ei = 4'(i + 1); ed = 4'(10 - i);
      push(ei, ed);
    end
    checks++;
    if (fifo_count !== 3'd4 || uart_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_state got cnt=%0d ovf=%b want 4/1", fifo_count, uart_overflow);
    end
    tick(); tick();
    checks++;
    if ({cmd_valid, cmd_instr, cmd_data, cmd_src} !== {1'b1, 4'h1, 4'hA, 1'b0}) begin
      errors++;
      $display("FAIL ovf_head_stable got v=%b i=%h d=%h s=%b want 1/1/a/0",
               cmd_valid, cmd_instr, cmd_data, cmd_src);
    end
    cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int w = 0;
      while (!cmd_valid && w < 10) begin tick(); w++; end
      ei = 4'(k + 1); ed = 4'(10 - k);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_instr !== ei || cmd_data !== ed || cmd_src !== 1'b0) begin
        errors++;
        $display("FAIL ovf_drain%0d got v=%b i=%h d=%h s=%b want 1/%h/%h/0",
                 k, cmd_valid, cmd_instr, cmd_data, cmd_src, ei, ed);
      end
      $display("txn drain src=%0d instr=%h data=%h", cmd_src, cmd_instr, cmd_data);
      tick();
    end
    checks++;
    if (fifo_count !== 3'd0 || uart_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got cnt=%0d ovf=%b want 0/1", fifo_count, uart_overflow);
    end
    push(4'hF, 4'h0);
    tick();
    checks++;
    if (uart_overflow !== 1'b0 || fifo_count !== 3'd0 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flush_clear got ovf=%b cnt=%0d v=%b want 0/0/0", uart_overflow, fifo_count, cmd_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] seen[$];
    logic [8:0] want[3];
    int acks = 0;
    do_reset();
    cmd_ready = 1'b1;
    uart_valid = 1'b1; uart_instr = 4'h1; uart_data = 4'h1;
    tick();
    uart_instr = 4'h2; uart_data = 4'h2;
    pnl_req = 1'b1; pnl_instr = 4'h9; pnl_data = 4'h5;
    tick();
    uart_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (cmd_valid) begin
        seen.push_back({cmd_src, cmd_instr, cmd_data});
        $display("txn rr src=%0d instr=%h data=%h", cmd_src, cmd_instr, cmd_data);
      end
      if (pnl_ack) begin acks++; pnl_req = 1'b0; end
      tick();
    end
    want[0] = {1'b0, 4'h1, 4'h1};
    want[1] = {1'b1, 4'h9, 4'h5};
    want[2] = {1'b0, 4'h2, 4'h2};
    checks++;
    if (seen.size() != 3) begin
      errors++;
      $display("FAIL rr_count got %0d commands want 3", seen.size());
    end
    for (int k = 0; k < 3; k++) begin
      if (k < seen.size()) begin
        checks++;
        if (seen[k] !== want[k]) begin
          errors++;
          $display("FAIL rr_order%0d got %h want %h", k, seen[k], want[k]);
        end
      end
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL rr_ack got %0d pulses want 1", acks);
    end
  endtask

  task automatic test_flush_during_issue();
    do_reset();
    push(4'h4, 4'h1); push(4'h5, 4'h2); push(4'h6, 4'h3);
    checks++;
    if (fifo_count !== 3'd3 || {cmd_valid, cmd_instr, cmd_data} !== {1'b1, 4'h4, 4'h1}) begin
      errors++;
      $display("FAIL flush_setup got cnt=%0d v=%b i=%h d=%h want 3/1/4/1", fifo_count, cmd_valid, cmd_instr, cmd_data);
    end
    push(4'hF, 4'h0);
    checks++;
    if (fifo_count !== 3'd0 || {cmd_valid, cmd_instr, cmd_data, cmd_src} !== {1'b1, 4'h4, 4'h1, 1'b0}) begin
      errors++;
      $display("FAIL flush_hold got cnt=%0d v=%b i=%h d=%h want 0/1/4/1", fifo_count, cmd_valid, cmd_instr, cmd_data);
    end
    cmd_ready = 1'b1;
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || uart_overflow !== 1'b0) begin
      errors++;
      $display("FAIL flush_complete got v=%b cnt=%0d ovf=%b want 0/0/0", cmd_valid, fifo_count, uart_overflow);
    end
    tick(); tick();
    checks++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL flush_quiet got v=%b cnt=%0d want 0/0", cmd_valid, fifo_count);
    end
    push(4'h8, 4'h9);
    tick();
    checks++;
    if ({cmd_valid, cmd_instr, cmd_data, cmd_src} !== {1'b1, 4'h8, 4'h9, 1'b0}) begin
      errors++;
      $display("FAIL flush_reuse got v=%b i=%h d=%h s=%b want 1/8/9/0", cmd_valid, cmd_instr, cmd_data, cmd_src);
    end
    tick();
    cmd_ready = 1'b0;
    push(4'h1, 4'h2); push(4'h3, 4'h4);
    uart_valid = 1'b1; uart_instr = 4'hF; cmd_ready = 1'b1;
    tick();
    uart_valid = 1'b0;
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL flush_with_pop got v=%b cnt=%0d want 0/0", cmd_valid, fifo_count);
    end
  endtask

  task automatic test_full_with_pop();
    logic [3:0] wi[4];
    logic [3:0] wd[4];
    do_reset();
    for (int i = 0; i < 4; i++) push(4'(i + 1), 4'(i + 8));
    uart_valid = 1'b1; uart_instr = 4'h7; uart_data = 4'h7; cmd_ready = 1'b1;
    tick();
    uart_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || uart_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop got cnt=%0d ovf=%b want 4/0", fifo_count, uart_overflow);
    end
    wi[0] = 4'h2; wi[1] = 4'h3; wi[2] = 4'h4; wi[3] = 4'h7;
    wd[0] = 4'h9; wd[1] = 4'hA; wd[2] = 4'hB; wd[3] = 4'h7;
    for (int k = 0; k < 4; k++) begin
      int w = 0;
      while (!cmd_valid && w < 10) begin tick(); w++; end
      checks++;
      if (cmd_valid !== 1'b1 || cmd_instr !== wi[k] || cmd_data !== wd[k]) begin
        errors++;
        $display("FAIL full_drain%0d got v=%b i=%h d=%h want 1/%h/%h", k, cmd_valid, cmd_instr, cmd_data, wi[k], wd[k]);
      end
      $display("txn full src=%0d instr=%h data=%h", cmd_src, cmd_instr, cmd_data);
      tick();
    end
    checks++;
    if (fifo_count !== 3'd0 || uart_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_end got cnt=%0d ovf=%b want 0/0", fifo_count, uart_overflow);
    end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    do_reset();
    pnl_req = 1'b1; pnl_instr = 4'hC; pnl_data = 4'hD;
    tick();
    push(4'h2, 4'h3);
    checks++;
    if ({cmd_valid, cmd_instr, cmd_data, cmd_src} !== {1'b1, 4'hC, 4'hD, 1'b1} || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_setup got v=%b i=%h d=%h s=%b cnt=%0d want 1/c/d/1/1",
               cmd_valid, cmd_instr, cmd_data, cmd_src, fifo_count);
    end
    cmd_ready = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_async got v=%b cnt=%0d want 0/0", cmd_valid, fifo_count);
    end
    for (int c = 0; c < 3; c++) begin tick(); if (pnl_ack) acks++; end
    pnl_req = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin tick(); if (pnl_ack) acks++; end
    checks++;
    if (acks != 0 || cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_after got acks=%0d v=%b cnt=%0d want 0/0/0", acks, cmd_valid, fifo_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    bit m_busy = 0, m_ack = 0, m_last = 1, m_ovf = 0, m_src = 0;
    bit ack_n, up, pp, win;
    logic [3:0] m_instr = 4'h0, m_data = 4'h0;
    int ntx = 0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      uart_valid = ($urandom_range(0, 99) < 40);
      uart_instr = 4'($urandom_range(0, 14));
      uart_data  = 4'($urandom_range(0, 15));
      cmd_ready  = ($urandom_range(0, 99) < 45);
      if (m_ack) begin
        pnl_req = 1'b0;
      end else if (!pnl_req && $urandom_range(0, 99) < 20) begin
        pnl_req = 1'b1;
        pnl_instr = 4'($urandom_range(0, 15));
        pnl_data  = 4'($urandom_range(0, 15));
      end
      // Reference: what the arbiter must do at the coming edge.
      ack_n = 0;
      if (m_busy) begin
        if (cmd_ready) begin
          if (!m_src) void'(q.pop_front());
          m_last = m_src;
          ack_n = m_src;
          m_busy = 0;
          ntx++;
          $display("txn rand%0d src=%0d instr=%h data=%h", ntx, m_src, m_instr, m_data);
        end
      end else begin
        up = (q.size() != 0);
        pp = pnl_req && !m_ack;
        win = (up && pp) ? !m_last : pp;
        if (up || pp) begin
          m_busy = 1;
          m_src = win;
          if (win) begin m_instr = pnl_instr; m_data = pnl_data; end
          else     begin m_instr = q[0][7:4]; m_data = q[0][3:0]; end
        end
      end
      if (uart_valid) begin
        if (q.size() < DEPTH) q.push_back({uart_instr, uart_data});
        else m_ovf = 1;
      end
      m_ack = ack_n;
      tick();
      checks++;
      if (cmd_valid !== m_busy || fifo_count !== CW'(q.size()) || uart_overflow !== m_ovf || pnl_ack !== m_ack) begin
        errors++;
        $display("FAIL rand_ctrl cyc=%0d got v=%b cnt=%0d ovf=%b ack=%b want %b/%0d/%b/%b",
                 cyc, cmd_valid, fifo_count, uart_overflow, pnl_ack, m_busy, q.size(), m_ovf, m_ack);
      end
      if (m_busy) begin
        checks++;
        if ({cmd_src, cmd_instr, cmd_data} !== {m_src, m_instr, m_data}) begin
          errors++;
          $display("FAIL rand_cmd cyc=%0d got s=%b i=%h d=%h want %b/%h/%h",
                   cyc, cmd_src, cmd_instr, cmd_data, m_src, m_instr, m_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_uart();
    test_overflow();
    test_round_robin();
    test_flush_during_issue();
    test_full_with_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
